branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor: direct-mapped BTB plus one 2-bit saturating counter per entry.
- Produces the next-PC prediction in IF.
- Carries prediction metadata down its own IF→ID→EX pipeline and drives BranchPredictedE / BranchPredictedTakenE into the hazard unit, which flushes on mismatch.
- Trains from resolved branches in EX.

Parameters:
- INDEX_BITS, 6, log2 of BTB entries (64); index = PC[INDEX_BITS+1:2].
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).
- Derived, not overridable: TAG_BITS = 30-INDEX_BITS; tag = PC[31:INDEX_BITS+2].

Ports:
- clk in 1: core clock; all state updates on rising edge.
- rst_n in 1: synchronous, active-low reset.
- PCF in 32: current fetch PC.
- PredictedTakenF out 1: lookup hit AND counter[1].
- PredictedPCF out 32: BTB target if PredictedTakenF, else PCF+4.
- StallD in 1: hold IF/ID prediction register.
- FlushD in 1: clear IF/ID prediction register.
- StallE in 1: hold ID/EX prediction register; blocks training.
- FlushE in 1: clear ID/EX prediction register.
- BranchPredictedE out 1: EX instruction hit in BTB at fetch.
- BranchPredictedTakenE out 1: EX instruction was predicted taken.
- BrInstE in 1: EX instruction is a conditional branch (B-type).
- BranchE in 1: resolved outcome, 1 = taken.
- BrNPC in 32: resolved branch target.
- PCE in 32: PC of EX instruction.

Behaviour:
- Storage: per entry valid(1), tag(TAG_BITS), target(32), cnt(2).
- Reads are combinational from PCF; writes occur on the clock edge, so a same-cycle read of the index being trained returns the pre-update contents.
- Reset (rst_n=0 at edge):
  - All valid bits and cnt cleared; IF/ID and ID/EX prediction registers cleared.
  - Tag/target contents don't-care.
  - After reset: PredictedTakenF=0, PredictedPCF=PCF+4, BranchPredictedE=0, BranchPredictedTakenE=0.
  - Reset asserted mid-operation discards all state, including a pending training write in that cycle.
- HitF = valid[idxF] && tag[idxF]==tagF. PCF+4 wraps modulo 2^32.
- Metadata pipeline, 2 registers {hit, taken}:
  - IF/ID captures {HitF, PredictedTakenF} each cycle.
  - ID/EX captures the IF/ID value.
  - Per stage, flush clears to 0 and has priority over stall; stall holds; otherwise load.
  - Latency: the value visible in EX is exactly 2 unstalled cycles after fetch.
  - BranchPredictedE and BranchPredictedTakenE are direct register outputs.
- Training is enabled when BrInstE && !StallE.
  - FlushE does NOT block training: on a mispredict the hazard unit asserts FlushE in the same cycle the branch trains.
  - Index/tag are taken from PCE.
  - Hit, taken: cnt = sat_inc(cnt) (3 stays 3); target ← BrNPC.
  - Hit, not taken: cnt = sat_dec(cnt) (0 stays 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag, target=BrNPC, cnt=CNT_INIT; replaces any aliasing entry.
  - Miss, not taken: no write.
- Non-branch EX instructions (BrInstE=0), including JAL/JALR, never train.
- A stalled EX branch (StallE=1, e.g. cache miss) trains exactly once: in the first cycle StallE drops.

Optional Feature:
- Macro BRANCH_PRED_STATS_EN.
- Defined:
  - Adds outputs BrCountStat[31:0] and MispredCountStat[31:0], both synchronously reset to 0.
  - Both update on the training-enable condition.
  - BrCountStat increments per trained branch.
  - MispredCountStat increments when (BranchPredictedE ? BranchPredictedTakenE^BranchE : BranchE).
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then PCF=0x00000100 → PredictedTakenF=0, PredictedPCF=0x00000104; BranchPredictedE=0 two cycles later.
- Train a taken branch at PCE=0x100 (BrInstE=1, BranchE=1, BrNPC=0x80) → next cycle PCF=0x100 gives PredictedTakenF=1, PredictedPCF=0x80, cnt=2.
- Same branch trained not-taken once → PredictedTakenF=0, but BranchPredictedE=1 when it reaches EX. Train taken three more times → cnt saturates at 3, and one not-taken still predicts taken.
- Aliasing with INDEX_BITS=6: train 0x100 taken, then 0x200 taken (BrNPC=0x40) → lookup of 0x100 misses, 0x200 hits with target 0x40.
- Branch in EX with StallE=1 for 5 cycles, then released → exactly one counter update. FlushD/FlushE asserted with BrInstE=1 → training occurs and the ID/EX register reads 0 next cycle.
- BRANCH_PRED_STATS_EN defined: 4 branches with 1 mispredict → BrCountStat=4, MispredCountStat=1; reset mid-run → both 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped BTB with 2-bit counters,
// IF->ID->EX metadata pipeline, and EX-stage training. Optional stats via BRANCH_PRED_STATS_EN.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  CNT_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredictedTakenF,
  output logic [31:0] PredictedPCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        BranchPredictedE,
  output logic        BranchPredictedTakenE,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic [31:0] BrNPC,
  input  logic [31:0] PCE
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0] BrCountStat,
  output logic [31:0] MispredCountStat
`endif
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag    [ENTRIES];
  logic [31:0]         target [ENTRIES];
  logic [1:0]          cnt    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0]   tag_f;
  logic                  hit_f;

  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  hit_e;
  logic                  train_en;
  logic                  alloc;
  logic                  update;
  logic [1:0]            cnt_e;
  logic [1:0]            cnt_next;

  logic [1:0] meta_d;
  logic [1:0] meta_e;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  // Combinational lookup on the fetch PC.
  always_comb begin
    idx_f           = PCF[INDEX_BITS+1:2];
    tag_f           = PCF[31:INDEX_BITS+2];
    hit_f           = valid[idx_f] && (tag[idx_f] == tag_f);
    PredictedTakenF = hit_f && cnt[idx_f][1];
    PredictedPCF    = PredictedTakenF ? target[idx_f] : PCF + 32'd4;
  end

  // Training decode for the resolved branch in EX.
  always_comb begin
    idx_e    = PCE[INDEX_BITS+1:2];
    tag_e    = PCE[31:INDEX_BITS+2];
    hit_e    = valid[idx_e] && (tag[idx_e] == tag_e);
    train_en = BrInstE && !StallE;
    alloc    = train_en && !hit_e && BranchE;
    update   = train_en && hit_e;
    cnt_e    = cnt[idx_e];
    cnt_next = cnt_e;
    if (BranchE) begin
      if (cnt_e != 2'b11) cnt_next = cnt_e + 2'd1;
    end else begin
      if (cnt_e != 2'b00) cnt_next = cnt_e - 2'd1;
    end
  end

  // Valid bits and counters; reset drops any same-cycle training write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt[i] <= 2'b00;
    end else if (alloc) begin
      valid[idx_e] <= 1'b1;
      cnt[idx_e]   <= CNT_INIT;
    end else if (update) begin
      cnt[idx_e] <= cnt_next;
    end
  end

  // Tag and target arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (alloc) begin
        tag[idx_e]    <= tag_e;
        target[idx_e] <= BrNPC;
      end else if (update && BranchE) begin
        target[idx_e] <= BrNPC;
      end
    end
  end

  // {hit, taken} metadata pipeline; flush wins over stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_d <= 2'b00;
      meta_e <= 2'b00;
    end else begin
      if (FlushD)      meta_d <= 2'b00;
      else if (!StallD) meta_d <= {hit_f, PredictedTakenF};
      if (FlushE)      meta_e <= 2'b00;
      else if (!StallE) meta_e <= meta_d;
    end
  end

  assign BranchPredictedE      = meta_e[1];
  assign BranchPredictedTakenE = meta_e[0];

`ifdef BRANCH_PRED_STATS_EN
  logic mispred;
  assign mispred = BranchPredictedE ? (BranchPredictedTakenE ^ BranchE) : BranchE;

  // Branch and mispredict counters, advancing on each trained branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BrCountStat      <= 32'd0;
      MispredCountStat <= 32'd0;
    end else if (train_en) begin
      BrCountStat <= BrCountStat + 32'd1;
      if (mispred) MispredCountStat <= MispredCountStat + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredictedTakenF;
  logic [31:0] PredictedPCF;
  logic        StallD, FlushD, StallE, FlushE;
  logic        BranchPredictedE, BranchPredictedTakenE;
  logic        BrInstE, BranchE;
  logic [31:0] BrNPC, PCE;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] BrCountStat, MispredCountStat;
`endif

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF),
    .PredictedTakenF(PredictedTakenF), .PredictedPCF(PredictedPCF),
    .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
    .BranchPredictedE(BranchPredictedE), .BranchPredictedTakenE(BranchPredictedTakenE),
    .BrInstE(BrInstE), .BranchE(BranchE), .BrNPC(BrNPC), .PCE(PCE)
`ifdef BRANCH_PRED_STATS_EN
    , .BrCountStat(BrCountStat), .MispredCountStat(MispredCountStat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] val;
    logic [15:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   chk_id  = 0;

  function automatic string kind_name(input logic [3:0] k);
    case (k)
      4'd0: return "PredictedTakenF";
      4'd1: return "PredictedPCF";
      4'd2: return "BranchPredictedE";
      4'd3: return "BranchPredictedTakenE";
      4'd4: return "BrCountStat";
      default: return "MispredCountStat";
    endcase
  endfunction

  function automatic logic [31:0] actual(input logic [3:0] k);
    case (k)
      4'd0: return {31'd0, PredictedTakenF};
      4'd1: return PredictedPCF;
      4'd2: return {31'd0, BranchPredictedE};
      4'd3: return {31'd0, BranchPredictedTakenE};
`ifdef BRANCH_PRED_STATS_EN
      4'd4: return BrCountStat;
      4'd5: return MispredCountStat;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.kind);
      n_tests++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL check#%0d %s: got 0x%08h expected 0x%08h", e.id, kind_name(e.kind), a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] kind, input logic [31:0] val);
    exp_t e;
    chk_id++;
    e.kind = kind;
    e.val  = val;
    e.id   = 16'(chk_id);
    sb.push_back(e);
  endtask

  task automatic expect_f(input logic taken, input logic [31:0] pc);
    push(4'd0, {31'd0, taken});
    push(4'd1, pc);
  endtask

  task automatic expect_e(input logic hit, input logic taken);
    push(4'd2, {31'd0, hit});
    push(4'd3, {31'd0, taken});
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] npc);
    BrInstE = 1'b1;
    PCE     = pc;
    BranchE = taken;
    BrNPC   = npc;
  endtask

  task automatic idle();
    BrInstE = 1'b0;
    BranchE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; PCF = 32'h100;
    StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
    BrInstE = 0; BranchE = 0; BrNPC = 0; PCE = 0;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    expect_f(1'b0, 32'h104);
    expect_e(1'b0, 1'b0);
    step(); step();
    expect_e(1'b0, 1'b0);

    // Allocate a taken branch; same-cycle read sees old contents
    train(32'h100, 1'b1, 32'h80);
    expect_f(1'b0, 32'h104);
    step(); idle();
    expect_f(1'b1, 32'h80);
    step(); step();
    expect_e(1'b1, 1'b1);

    // One not-taken: cnt 2->1, target must not change
    train(32'h100, 1'b0, 32'h999);
    expect_f(1'b1, 32'h80);
    step(); idle();
    expect_f(1'b0, 32'h104);
    step(); step();
    expect_e(1'b1, 1'b0);

    // Three taken: 1->2->3->3, then not-taken twice: 3->2 (taken), 2->1 (not)
    train(32'h100, 1'b1, 32'h80);
    step(); step(); step(); idle();
    expect_f(1'b1, 32'h80);
    train(32'h100, 1'b0, 32'h0);
    step(); idle();
    expect_f(1'b1, 32'h80);
    train(32'h100, 1'b0, 32'h0);
    step(); idle();
    expect_f(1'b0, 32'h104);

    // Hit-taken retrains target
    train(32'h100, 1'b1, 32'h88);
    step(); idle();
    expect_f(1'b1, 32'h88);

    // Aliasing: 0x200 shares index 0 with 0x100
    train(32'h200, 1'b1, 32'h40);
    step(); idle();
    expect_f(1'b0, 32'h104);
    step();
    PCF = 32'h200;
    expect_f(1'b1, 32'h40);
    step();
    PCF = 32'hFFFF_FFFC;
    expect_f(1'b0, 32'h0);
    step();

    // Stalled EX branch trains exactly once on release (cnt 2->1)
    PCF = 32'h200;
    step(); step();
    train(32'h200, 1'b0, 32'h0);
    StallE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_f(1'b1, 32'h40);
      step();
    end
    StallE = 1'b0;
    expect_f(1'b1, 32'h40);
    step(); idle();
    expect_f(1'b0, 32'h204);
    train(32'h200, 1'b1, 32'h40);
    step(); idle();
    expect_f(1'b1, 32'h40);

    // Flush does not block training; ID/EX reads 0 after flush (cnt 2->3)
    step(); step();
    expect_e(1'b1, 1'b1);
    train(32'h200, 1'b1, 32'h40);
    FlushD = 1'b1; FlushE = 1'b1;
    step(); idle();
    FlushD = 1'b0; FlushE = 1'b0;
    expect_e(1'b0, 1'b0);
    step();
    expect_e(1'b0, 1'b0);
    train(32'h200, 1'b0, 32'h0);
    step(); idle();
    expect_f(1'b1, 32'h40);

    // FlushD has priority over StallD
    step(); step();
    FlushD = 1'b1; StallD = 1'b1;
    step();
    FlushD = 1'b0;
    step();
    StallD = 1'b0;
    expect_e(1'b0, 1'b0);

    // Reset mid-operation discards the pending allocation
    train(32'h400, 1'b1, 32'h10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; idle();
    PCF = 32'h400;
    expect_f(1'b0, 32'h404);
    expect_e(1'b0, 1'b0);
`ifdef BRANCH_PRED_STATS_EN
    push(4'd4, 32'd0);
    push(4'd5, 32'd0);
    step();
    train(32'h300, 1'b0, 32'h0);
    step(); step(); step();
    train(32'h300, 1'b1, 32'h20);
    step(); idle();
    push(4'd4, 32'd4);
    push(4'd5, 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push(4'd4, 32'd0);
    push(4'd5, 32'd0);
`endif
    step();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
